// File: rtl/alu8_mult_seq.sv
// Sequential 8x8 unsigned shift-add multiplier that drives an external 8-bit ALU, one operation per clock.
// Optional MULT_EARLY_SKIP_EN: skips the ADD state when the current multiplier LSB is 0.
module alu8_mult_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [3:0]  alu_op,
  output logic        alu_shr,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  output logic        alu_bcd,
  input  logic [7:0]  alu_out,
  input  logic        alu_co
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 3;

  localparam logic [3:0]    OP_ADD  = 4'b0011;
  localparam logic [3:0]    OP_IDLE = 4'b1111;
  localparam logic [CW-1:0] CNT_LAST = CW'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   mcand;
  logic [DW-1:0]   hi;
  logic [DW-1:0]   lo;
  logic            c;
  logic [CW-1:0]   cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef MULT_EARLY_SKIP_EN
          state_nxt = b[0] ? S_ADD : S_SHIFT;
`else
          state_nxt = S_ADD;
`endif
        end
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
        end else begin
`ifdef MULT_EARLY_SKIP_EN
          // lo[1] becomes the LSB after this cycle's shift
          state_nxt = lo[1] ? S_ADD : S_SHIFT;
`else
          state_nxt = S_ADD;
`endif
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU control: one add or one right shift of {c,hi} per cycle
  always_comb begin
    alu_op  = OP_IDLE;
    alu_shr = 1'b0;
    alu_ai  = '0;
    alu_bi  = '0;
    alu_ci  = 1'b0;
    case (state)
      S_ADD: begin
        alu_op = OP_ADD;
        alu_ai = hi;
        alu_bi = lo[0] ? mcand : '0;
      end
      S_SHIFT: begin
        alu_shr = 1'b1;
        alu_ai  = hi;
        alu_ci  = c;
      end
      default: begin
        alu_op = OP_IDLE;
      end
    endcase
  end

  assign alu_bcd = 1'b0;

  // Handshake flags follow the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == S_ADD) || (state_nxt == S_SHIFT);
      done <= (state_nxt == S_DONE);
    end
  end

  // Datapath: {hi,lo} accumulates the product, lo shifts out the multiplier
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
          end
        end
        S_ADD: begin
          hi <= alu_out;
          c  <= alu_co;
        end
        S_SHIFT: begin
          hi  <= alu_out;
          lo  <= {alu_co, lo[DW-1:1]};
          cnt <= cnt + CW'(1);
`ifdef MULT_EARLY_SKIP_EN
          c   <= 1'b0;
`endif
          if (cnt == CNT_LAST) product <= PW'({alu_out, alu_co, lo[DW-1:1]});
        end
        default: begin
          c <= c;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu8_mult_seq.sv
// Bench for alu8_mult_seq with a behavioural ALU in the loop and a product/latency reference model.
module tb_alu8_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [3:0]  alu_op;
  logic        alu_shr;
  logic [7:0]  alu_ai;
  logic [7:0]  alu_bi;
  logic        alu_ci;
  logic        alu_bcd;
  logic [7:0]  alu_out;
  logic        alu_co;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_prod;

  always #5 clk = ~clk;

  alu8_mult_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu_op  (alu_op),
    .alu_shr (alu_shr),
    .alu_ai  (alu_ai),
    .alu_bi  (alu_bi),
    .alu_ci  (alu_ci),
    .alu_bcd (alu_bcd),
    .alu_out (alu_out),
    .alu_co  (alu_co)
  );

  // Behavioural 8-bit ALU: add with carry, or right shift through carry
  always_comb begin
    if (alu_shr)
      {alu_co, alu_out} = {alu_ai[0], alu_ci, alu_ai[7:1]};
    else if (alu_op == 4'b0011)
      {alu_co, alu_out} = 9'(alu_ai) + 9'(alu_bi) + 9'(alu_ci);
    else
      {alu_co, alu_out} = 9'h000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] bv);
`ifdef MULT_EARLY_SKIP_EN
    return 9 + $countones(bv);
`else
    return 17;
`endif
  endfunction

  // One multiply; cycle 0 is the accept cycle, samples taken on the falling edge
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input bit hold, input string tag);
    int lat;
    int ndone;
    int nbusy;
    int ovl;
    int elat;
    bit seen2;
    logic [15:0] prod;
    logic [15:0] eprod;
    lat   = -1;
    ndone = 0;
    nbusy = 0;
    ovl   = 0;
    prod  = '0;
    elat  = exp_lat(tbv);
    eprod = 16'(ta) * 16'(tbv);
    @(negedge clk);
    a = ta;
    b = tbv;
    start = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat  = cyc;
          prod = product;
        end
      end
      if (busy && lat < 0) nbusy++;
      if (busy && done) ovl++;
      if (cyc == 1) check({tag, "/prev_held"}, 32'(product), 32'(last_prod));
      if (hold && cyc == elat + 2) begin
        check({tag, "/reaccept"}, 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (!hold && lat >= 0 && cyc >= lat + 2) break;
    end
    check({tag, "/latency"}, 32'(lat), 32'(elat));
    check({tag, "/product"}, 32'(prod), 32'(eprod));
    check({tag, "/done_count"}, 32'(ndone), 32'd1);
    check({tag, "/busy_cycles"}, 32'(nbusy), 32'(elat - 1));
    check({tag, "/busy_done_overlap"}, 32'(ovl), 32'd0);
    if (hold) begin
      seen2 = 1'b0;
      for (int k = 0; k < 30 && !seen2; k++) begin
        @(negedge clk);
        if (done) seen2 = 1'b1;
      end
      check({tag, "/second_done"}, 32'(seen2), 32'd1);
      @(negedge clk);
    end
    check({tag, "/product_hold"}, 32'(product), 32'(eprod));
    last_prod = eprod;
  endtask

  initial begin
    int ndone;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    last_prod = '0;
    repeat (3) @(negedge clk);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/product", 32'(product), 32'd0);
    check("rst/alu_op", 32'(alu_op), 32'hF);
    check("rst/alu_shr", 32'(alu_shr), 32'd0);
    check("rst/alu_ai", 32'(alu_ai), 32'd0);
    check("rst/alu_bi", 32'(alu_bi), 32'd0);
    check("rst/alu_ci", 32'(alu_ci), 32'd0);
    check("rst/alu_bcd", 32'(alu_bcd), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle/busy", 32'(busy), 32'd0);

    run_op(8'h0F, 8'h0F, 1'b0, "t1");
    run_op(8'hFF, 8'hFF, 1'b0, "t2a");
    run_op(8'h00, 8'hAB, 1'b0, "t2b");
    run_op(8'h12, 8'h34, 1'b1, "t3");

    // Reset in the middle of an operation abandons it
    @(negedge clk);
    a = 8'h80;
    b = 8'h02;
    start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 5) check("t4/busy_before", 32'(busy), 32'd1);
      if (cyc == 6) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check("t4/busy", 32'(busy), 32'd0);
    check("t4/done", 32'(done), 32'd0);
    check("t4/product", 32'(product), 32'd0);
    check("t4/alu_op", 32'(alu_op), 32'hF);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t4/no_done", 32'(ndone), 32'd0);
    last_prod = '0;

    run_op(8'hC3, 8'h00, 1'b0, "t5a");
    run_op(8'hC3, 8'h01, 1'b0, "t5b");
    run_op(8'hC3, 8'hFF, 1'b0, "t5c");

    for (int i = 0; i < 2000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
